// File: rtl/FIR_pkg.sv
// Shared types and helpers for the FIR accelerator MCA scheduler.
//   sched_state_e : scheduler FSM states
//   clog2_groups  : width of the group-address bus for K taps in groups of MCA
package FIR_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // A single group still needs a 1-bit address bus, so clamp the width at 1.
  function automatic int clog2_groups(input int k, input int mca);
    int g;
    g = k / mca;
    return (g > 1) ? $clog2(g) : 1;
  endfunction

endpackage

// File: rtl/mca_group_sum.sv
// Combinational +/-h reduction of one tap group.
//   h_grp_i : MCA*N signed coefficients, element i at [i*W +: W], i = t*N + n
//   s_grp_i : MCA*N control bits, element i at [i]; 1 adds h, 0 subtracts h
//   sum_o   : signed sum, sign-extended to ACC_WIDTH
module mca_group_sum #(
  parameter int MCA_NUM_ADDITIONS = 16,
  parameter int N                 = 8,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int ACC_WIDTH         = 48
) (
  input  logic [MCA_NUM_ADDITIONS*N*WIDTH_COEFFICIENT-1:0] h_grp_i,
  input  logic [MCA_NUM_ADDITIONS*N-1:0]                   s_grp_i,
  output logic signed [ACC_WIDTH-1:0]                      sum_o
);

  localparam int NE = MCA_NUM_ADDITIONS * N;
  localparam int W  = WIDTH_COEFFICIENT;

  logic [W-1:0]                h_v;
  logic signed [ACC_WIDTH-1:0] ext_v;

  always_comb begin
    sum_o = '0;
    h_v   = '0;
    ext_v = '0;
    for (int i = 0; i < NE; i++) begin
      h_v   = h_grp_i[i*W +: W];
      ext_v = {{(ACC_WIDTH-W){h_v[W-1]}}, h_v};
      if (s_grp_i[i]) sum_o = sum_o + ext_v;
      else            sum_o = sum_o - ext_v;
    end
  end

endmodule

// File: rtl/fir_mca_scheduler.sv
// Sequences one FIR output-sample calculation over the H/S banks.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : request a calculation (level, sampled each cycle)
//   busy        : calculation in progress (ISSUE, DRAIN, DONE)
//   done        : 1-cycle pulse, sample_out/sat valid
//   grp_rd_en   : group read request, grp_addr = group index 0..G-1
//   h_grp/s_grp : group data, valid 1 cycle after grp_rd_en
//   sample_out  : signed saturated result, held until next done
//   sat         : result was clipped
// Pipeline: read (stage 1) -> registered group sum (stage 2) -> accumulate
// (stage 3). The two DRAIN cycles cover stages 2 and 3 of the last group.
// Bank handshake: grp_rd_en is a request with no ready; data must appear
// exactly one cycle later, and is ignored in any other cycle.
module fir_mca_scheduler
  import FIR_pkg::*;
#(
  parameter int N                 = 8,
  parameter int K                 = 256,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int MCA_NUM_ADDITIONS = 16,
  parameter int ACC_WIDTH         = 48
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              grp_rd_en,
  output logic [clog2_groups(K, MCA_NUM_ADDITIONS)-1:0]     grp_addr,
  input  logic [MCA_NUM_ADDITIONS*N*WIDTH_COEFFICIENT-1:0]  h_grp,
  input  logic [MCA_NUM_ADDITIONS*N-1:0]                    s_grp,
  output logic [WIDTH_COEFFICIENT-1:0]                      sample_out,
  output logic                                              sat
);

  localparam int W  = WIDTH_COEFFICIENT;
  localparam int G  = K / MCA_NUM_ADDITIONS;
  localparam int AW = clog2_groups(K, MCA_NUM_ADDITIONS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(G - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = {{(ACC_WIDTH-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = {{(ACC_WIDTH-W+1){1'b1}}, {(W-1){1'b0}}};

  if (K % MCA_NUM_ADDITIONS != 0) begin : g_chk_k
    $error("K must be a multiple of MCA_NUM_ADDITIONS");
  end
  if (ACC_WIDTH < W + $clog2(K * N) + 1) begin : g_chk_acc
    $error("ACC_WIDTH too small for K*N terms of WIDTH_COEFFICIENT bits");
  end

  sched_state_e                state_q, state_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic                        drain_q, drain_d;
  logic                        rd_pend_q;
  logic                        gsum_vld_q;
  logic signed [ACC_WIDTH-1:0] gsum_q, gsum_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [W-1:0]                sample_q, sample_d;
  logic                        sat_q, sat_d;
  logic signed [ACC_WIDTH-1:0] grp_sum;
  logic                        clr_acc;
  logic                        ld_out;

  mca_group_sum #(
    .MCA_NUM_ADDITIONS (MCA_NUM_ADDITIONS),
    .N                 (N),
    .WIDTH_COEFFICIENT (W),
    .ACC_WIDTH         (ACC_WIDTH)
  ) u_group_sum (
    .h_grp_i (h_grp),
    .s_grp_i (s_grp),
    .sum_o   (grp_sum)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    clr_acc = 1'b0;
    ld_out  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          addr_d  = '0;
          clr_acc = 1'b1;
        end
      end
      ISSUE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          addr_d  = '0;
          drain_d = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = DONE;
          ld_out  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        // A start here chains straight into the next calculation.
        if (start) begin
          state_d = ISSUE;
          addr_d  = '0;
          clr_acc = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus data is only folded in when a read was issued the cycle before.
  assign gsum_d = rd_pend_q ? grp_sum : '0;

  always_comb begin
    if (clr_acc)         acc_d = '0;
    else if (gsum_vld_q) acc_d = acc_q + gsum_q;
    else                 acc_d = acc_q;
  end

  // The result is captured from acc_d on entry to DONE, when the last
  // group sum is being added in.
  always_comb begin
    sample_d = sample_q;
    sat_d    = sat_q;
    if (ld_out) begin
      if (acc_d > OUT_MAX) begin
        sample_d = OUT_MAX[W-1:0];
        sat_d    = 1'b1;
      end else if (acc_d < OUT_MIN) begin
        sample_d = OUT_MIN[W-1:0];
        sat_d    = 1'b1;
      end else begin
        sample_d = acc_d[W-1:0];
        sat_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      drain_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      gsum_vld_q <= 1'b0;
      gsum_q     <= '0;
      acc_q      <= '0;
      sample_q   <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      rd_pend_q  <= (state_q == ISSUE);
      gsum_vld_q <= rd_pend_q;
      gsum_q     <= gsum_d;
      acc_q      <= acc_d;
      sample_q   <= sample_d;
      sat_q      <= sat_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign grp_rd_en  = (state_q == ISSUE);
  assign grp_addr   = addr_q;
  assign sample_out = sample_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_fir_mca_scheduler.sv
// Bench for fir_mca_scheduler: default-size instance (K=256, N=8) with
// uniform-bank vectors, plus a small instance (K=32, N=3) with random banks.
module tb_fir_mca_scheduler;

  localparam int W   = 32;
  localparam int MCA = 16;
  localparam int K1  = 256;
  localparam int N1  = 8;
  localparam int G1  = K1 / MCA;
  localparam int K2  = 32;
  localparam int N2  = 3;
  localparam int G2  = K2 / MCA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 1 (default size) ----------------
  logic                   start1, busy1, done1, rd1, sat1;
  logic [3:0]             addr1;
  logic [MCA*N1*W-1:0]    h1;
  logic [MCA*N1-1:0]      s1;
  logic [W-1:0]           samp1;

  fir_mca_scheduler u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .grp_rd_en(rd1), .grp_addr(addr1), .h_grp(h1), .s_grp(s1),
    .sample_out(samp1), .sat(sat1)
  );

  // ---------------- DUT 2 (K=32, N=3) ----------------
  logic                   start2, busy2, done2, rd2, sat2;
  logic [0:0]             addr2;
  logic [MCA*N2*W-1:0]    h2;
  logic [MCA*N2-1:0]      s2;
  logic [W-1:0]           samp2;

  fir_mca_scheduler #(.N(N2), .K(K2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .grp_rd_en(rd2), .grp_addr(addr2), .h_grp(h2), .s_grp(s2),
    .sample_out(samp2), .sat(sat2)
  );

  // ---------------- bank models (1-cycle latency, junk otherwise) ----------------
  logic [W-1:0] hval;
  logic         sval;
  int           hmem [K2][N2];
  bit           smem [K2][N2];

  always @(posedge clk) begin
    if (rd1) begin
      h1 <= {(MCA*N1){hval}};
      s1 <= {(MCA*N1){sval}};
    end else begin
      for (int i = 0; i < MCA*N1; i++) h1[i*W +: W] <= $urandom;
      for (int i = 0; i < MCA*N1; i++) s1[i] <= 1'($urandom);
    end
  end

  always @(posedge clk) begin
    if (rd2) begin
      for (int t = 0; t < MCA; t++)
        for (int n = 0; n < N2; n++) begin
          h2[(t*N2+n)*W +: W] <= hmem[int'(addr2)*MCA + t][n];
          s2[t*N2+n]          <= smem[int'(addr2)*MCA + t][n];
        end
    end else begin
      for (int i = 0; i < MCA*N2; i++) h2[i*W +: W] <= $urandom;
      for (int i = 0; i < MCA*N2; i++) s2[i] <= 1'($urandom);
    end
  end

  // ---------------- scoreboard ----------------
  logic [W:0] exp1_q[$];
  int         t1_q[$];
  logic [W:0] exp2_q[$];
  int         t2_q[$];
  int compared   = 0;
  int mismatched = 0;
  int addr1_exp  = 0;
  int addr2_exp  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [W:0] e;
    int         tt;
    if (reset) begin
      addr1_exp = 0;
      addr2_exp = 0;
    end else begin
      if (rd1) begin
        check("grp_addr1", 64'(addr1), 64'(addr1_exp));
        addr1_exp = (addr1_exp + 1) % G1;
      end
      if (rd2) begin
        check("grp_addr2", 64'(addr2), 64'(addr2_exp));
        addr2_exp = (addr2_exp + 1) % G2;
      end
      if (done1) begin
        if (exp1_q.size() == 0) check("done1_unexpected", 64'd1, 64'd0);
        else begin
          e  = exp1_q.pop_front();
          tt = t1_q.pop_front();
          check("sample1", 64'({sat1, samp1}), 64'(e));
          check("done1_cycle", 64'(cyc), 64'(tt));
        end
      end
      if (done2) begin
        if (exp2_q.size() == 0) check("done2_unexpected", 64'd1, 64'd0);
        else begin
          e  = exp2_q.pop_front();
          tt = t2_q.pop_front();
          check("sample2", 64'({sat2, samp2}), 64'(e));
          check("done2_cycle", 64'(cyc), 64'(tt));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain1(input int budget);
    int n = 0;
    while (exp1_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp1_q.size() != 0) begin
      check("timeout1", 64'(exp1_q.size()), 64'd0);
      exp1_q.delete();
      t1_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_drain2(input int budget);
    int n = 0;
    while (exp2_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp2_q.size() != 0) begin
      check("timeout2", 64'(exp2_q.size()), 64'd0);
      exp2_q.delete();
      t2_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run1(input logic [W-1:0] hv, input logic sv,
                      input logic [W-1:0] exp_s, input logic exp_sat);
    @(negedge clk);
    hval   = hv;
    sval   = sv;
    start1 = 1'b1;
    exp1_q.push_back({exp_sat, exp_s});
    t1_q.push_back(cyc + G1 + 3);
    @(negedge clk);
    start1 = 1'b0;
    wait_drain1(60);
  endtask

  task automatic run2_random();
    longint acc = 0;
    logic [W-1:0] es;
    logic esat;
    for (int t = 0; t < K2; t++)
      for (int n = 0; n < N2; n++) begin
        hmem[t][n] = int'($urandom_range(2000, 0)) - 1000;
        smem[t][n] = 1'($urandom_range(1, 0));
        acc += smem[t][n] ? longint'(hmem[t][n]) : -longint'(hmem[t][n]);
      end
    if (acc > 64'sd2147483647)       begin es = 32'h7FFFFFFF; esat = 1'b1; end
    else if (acc < -64'sd2147483648) begin es = 32'h80000000; esat = 1'b1; end
    else                             begin es = acc[W-1:0];   esat = 1'b0; end
    @(negedge clk);
    start2 = 1'b1;
    exp2_q.push_back({esat, es});
    t2_q.push_back(cyc + G2 + 3);
    @(negedge clk);
    start2 = 1'b0;
    wait_drain2(30);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  64'(busy1),  64'd0);
    check({tag, "_done"},  64'(done1),  64'd0);
    check({tag, "_rd"},    64'(rd1),    64'd0);
    check({tag, "_addr"},  64'(addr1),  64'd0);
    check({tag, "_samp"},  64'(samp1),  64'd0);
    check({tag, "_sat"},   64'(sat1),   64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] h;
    logic         s;
    logic [W-1:0] exp_s;
    logic         exp_sat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int k;

    // result = 2048 * (s ? h : -h), clipped to 32-bit signed
    vecs[0]  = '{32'h00000001, 1'b1, 32'h00000800, 1'b0};
    vecs[1]  = '{32'h00000001, 1'b0, 32'hFFFFF800, 1'b0};
    vecs[2]  = '{32'h40000000, 1'b1, 32'h7FFFFFFF, 1'b1};
    vecs[3]  = '{32'h40000000, 1'b0, 32'h80000000, 1'b1};
    vecs[4]  = '{32'h000FFFFF, 1'b1, 32'h7FFFF800, 1'b0};
    vecs[5]  = '{32'h00100000, 1'b1, 32'h7FFFFFFF, 1'b1};
    vecs[6]  = '{32'h00100000, 1'b0, 32'h80000000, 1'b0};
    vecs[7]  = '{32'hFFF00000, 1'b0, 32'h7FFFFFFF, 1'b1};
    vecs[8]  = '{32'hFFFFFFFD, 1'b1, 32'hFFFFE800, 1'b0};
    vecs[9]  = '{32'h80000000, 1'b0, 32'h7FFFFFFF, 1'b1};
    vecs[10] = '{32'h80000000, 1'b1, 32'h80000000, 1'b1};
    vecs[11] = '{32'h00000000, 1'b1, 32'h00000000, 1'b0};

    reset  = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    hval   = '0;
    sval   = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_busy2", 64'(busy2), 64'd0);
    check("reset_samp2", 64'(samp2), 64'd0);
    #2 reset = 1'b0;

    // table-driven single calculations
    for (int i = 0; i < 12; i++)
      run1(vecs[i].h, vecs[i].s, vecs[i].exp_s, vecs[i].exp_sat);

    // start held high: three back-to-back calculations, one every 19 cycles
    @(negedge clk);
    hval   = 32'd1;
    sval   = 1'b1;
    k      = cyc;
    start1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp1_q.push_back({1'b0, 32'h00000800});
      t1_q.push_back(k + i * (G1 + 3));
    end
    repeat (39) @(negedge clk);
    start1 = 1'b0;
    wait_drain1(80);
    repeat (20) @(negedge clk);

    // start pulses during ISSUE and DRAIN are ignored
    @(negedge clk);
    hval   = 32'd2;
    sval   = 1'b0;
    k      = cyc;
    start1 = 1'b1;
    exp1_q.push_back({1'b0, 32'hFFFFF000});
    t1_q.push_back(k + G1 + 3);
    @(negedge clk); start1 = 1'b0;
    repeat (2) @(negedge clk); start1 = 1'b1;
    @(negedge clk);            start1 = 1'b0;
    repeat (6) @(negedge clk); start1 = 1'b1;
    @(negedge clk);            start1 = 1'b0;
    repeat (6) @(negedge clk); start1 = 1'b1;
    repeat (2) @(negedge clk); start1 = 1'b0;
    wait_drain1(40);
    repeat (25) @(negedge clk);

    // reset in the middle of ISSUE, then a fresh calculation
    @(negedge clk);
    hval   = 32'd1;
    sval   = 1'b1;
    k      = cyc;
    start1 = 1'b1;
    exp1_q.push_back({1'b0, 32'h00000800});
    t1_q.push_back(k + G1 + 3);
    @(negedge clk); start1 = 1'b0;
    repeat (7) @(negedge clk);
    check("addr_before_reset", 64'(addr1), 64'd7);
    #2 reset = 1'b1;
    #1 check_idle_outputs("midreset");
    exp1_q.delete();
    t1_q.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (25) @(negedge clk);
    run1(32'd1, 1'b1, 32'h00000800, 1'b0);

    // small instance with random banks against the reference sum
    for (int i = 0; i < 4; i++) run2_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
